rv32i_control_fsm: RTL and testbench

Multi-cycle sequencer for the RV32I core. It takes the one-hot instruction class produced by the decoder and steps the datapath through fetch, decode, execute, memory and writeback. It drives the memory request handshake, the instruction-register, PC and register-file write enables, and the PC and writeback source selects. It also keeps a retired-instruction counter and halts on SYSTEM or illegal opcodes.

---
 rtl/rv32i_pkg.sv | 61 ++++++
 rtl/rv32i_control_fsm.sv | 198 +++++++++++++++++++
 tb/tb_rv32i_control_fsm.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I multi-cycle core: sequencer states, decoder
// class bit positions and the PC / writeback source encodings.
// Latency: n/a (types only). Backpressure: n/a.
//
// Contents:
//   state_t    - sequencer state encoding
//   OPC_*      - bit index of each instruction class in the one-hot op_class
//   pc_sel_t   - next-PC source select
//   wb_sel_t   - register-file writeback source select
//   is_onehot  - true when exactly one op_class bit is set

package rv32i_pkg;

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6
  } state_t;

  // Width and bit positions of the decoder's one-hot class vector.
  localparam int OPC_W      = 10;
  localparam int OPC_ALUREG = 0;
  localparam int OPC_ALUIMM = 1;
  localparam int OPC_BRANCH = 2;
  localparam int OPC_JALR   = 3;
  localparam int OPC_JAL    = 4;
  localparam int OPC_AUIPC  = 5;
  localparam int OPC_LUI    = 6;
  localparam int OPC_LOAD   = 7;
  localparam int OPC_STORE  = 8;
  localparam int OPC_SYSTEM = 9;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,  // sequential
    PC_IMM   = 2'd1,  // PC + branch/jump immediate
    PC_ALU   = 2'd2   // ALU result with bit 0 cleared (JALR)
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU   = 2'd0,
    WB_LOAD  = 2'd1,
    WB_PC4   = 2'd2,
    WB_UIMM  = 2'd3
  } wb_sel_t;

  // Population count of exactly one. A class vector with zero or several
  // bits set means the decoder did not recognise the opcode.
  function automatic logic is_onehot(input logic [OPC_W-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < OPC_W; i++) begin
      cnt = cnt + int'(v[i]);
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/rv32i_control_fsm.sv
// Multi-cycle sequencer: steps the datapath through fetch/decode/execute/mem/wb.
// Latency: 3 cycles per ALU/jump/branch, 4 per store, 5 per load (zero-wait).
// Backpressure: FETCH and MEM hold mem_req and stall until mem_ready.
//
// Ports:
//   clk, reset     - core clock; asynchronous active-high reset
//   op_class       - one-hot instruction class from the decoder (OPC_* order)
//   take_branch    - branch comparator result, used in EXECUTE for Branch
//   mem_ready      - memory completes the current request this cycle
//   mem_req/mem_we/mem_addr_sel - memory request, store strobe, address source
//   instr_we, pc_we, rf_we       - instruction register, PC, register-file writes
//   pc_sel, wb_sel               - next-PC and writeback source selects
//   halted, illegal              - core stopped; stop caused by a bad op_class
//   instret                      - retired-instruction counter (wraps)

module rv32i_control_fsm
  import rv32i_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] op_class,
  input  logic             take_branch,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             instr_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic             illegal,
  output logic [31:0]      instret
);

  state_t      r_state;
  state_t      w_state_nxt;

  // Store/load distinction captured in EXECUTE so MEM ignores later
  // changes on op_class (the IR may not be stable past EXECUTE).
  logic        r_is_store;
  logic        r_illegal;
  logic [31:0] r_instret;

  logic        w_mem_req;
  logic        w_mem_we;
  logic        w_mem_addr_sel;
  logic        w_instr_we;
  logic        w_pc_we;
  logic        w_rf_we;
  logic        w_set_illegal;
  pc_sel_t     w_pc_sel;
  wb_sel_t     w_wb_sel;

  // --------------------------------------------------------------------
  // State and bookkeeping registers
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_START;
      r_is_store <= 1'b0;
      r_illegal  <= 1'b0;
      r_instret  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_EXECUTE) begin
        r_is_store <= op_class[OPC_STORE];
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
      // Every PC update retires exactly one instruction; natural wrap.
      if (w_pc_we) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  // --------------------------------------------------------------------
  // Next state and output decode
  // --------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr_sel = 1'b0;
    w_instr_we     = 1'b0;
    w_pc_we        = 1'b0;
    w_rf_we        = 1'b0;
    w_set_illegal  = 1'b0;
    w_pc_sel       = PC_PLUS4;
    w_wb_sel       = WB_ALU;

    case (r_state)
      ST_START: begin
        w_state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_instr_we  = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end

      // Register-file read cycle; nothing is written.
      ST_DECODE: begin
        w_state_nxt = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        if (!is_onehot(op_class)) begin
          w_set_illegal = 1'b1;
          w_state_nxt   = ST_HALT;
        end else if (op_class[OPC_LOAD] || op_class[OPC_STORE]) begin
          w_state_nxt = ST_MEM;
        end else if (op_class[OPC_SYSTEM]) begin
          w_state_nxt = ST_HALT;
        end else begin
          // Every remaining class completes here.
          w_pc_we     = 1'b1;
          w_state_nxt = ST_FETCH;
          if (op_class[OPC_ALUREG] || op_class[OPC_ALUIMM] || op_class[OPC_AUIPC]) begin
            w_rf_we  = 1'b1;
            w_wb_sel = WB_ALU;
          end
          if (op_class[OPC_LUI]) begin
            w_rf_we  = 1'b1;
            w_wb_sel = WB_UIMM;
          end
          if (op_class[OPC_JAL]) begin
            w_rf_we  = 1'b1;
            w_wb_sel = WB_PC4;
            w_pc_sel = PC_IMM;
          end
          if (op_class[OPC_JALR]) begin
            w_rf_we  = 1'b1;
            w_wb_sel = WB_PC4;
            w_pc_sel = PC_ALU;
          end
          if (op_class[OPC_BRANCH]) begin
            w_pc_sel = take_branch ? PC_IMM : PC_PLUS4;
          end
        end
      end

      // Address source and write strobe depend only on registered state,
      // so they stay stable for the whole request.
      ST_MEM: begin
        w_mem_req      = 1'b1;
        w_mem_addr_sel = 1'b1;
        w_mem_we       = r_is_store;
        if (mem_ready) begin
          if (r_is_store) begin
            w_pc_we     = 1'b1;
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_WB;
          end
        end
      end

      ST_WB: begin
        w_rf_we     = 1'b1;
        w_wb_sel    = WB_LOAD;
        w_pc_we     = 1'b1;
        w_state_nxt = ST_FETCH;
      end

      // Sticky: only reset leaves.
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end

      default: begin
        w_state_nxt = ST_START;
      end
    endcase
  end

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign mem_req      = w_mem_req;
  assign mem_we       = w_mem_we;
  assign mem_addr_sel = w_mem_addr_sel;
  assign instr_we     = w_instr_we;
  assign pc_we        = w_pc_we;
  assign rf_we        = w_rf_we;
  assign pc_sel       = w_pc_sel;
  assign wb_sel       = w_wb_sel;
  assign halted       = (r_state == ST_HALT);
  assign illegal      = r_illegal;
  assign instret      = r_instret;

endmodule

// File: tb/tb_rv32i_control_fsm.sv
// Directed self-checking bench for rv32i_control_fsm.
// Inputs are driven 1 ns after the rising edge, outputs sampled 1 ns later.
module tb_rv32i_control_fsm;
  import rv32i_pkg::*;

  logic             clk;
  logic             reset;
  logic [OPC_W-1:0] op_class;
  logic             take_branch;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             mem_addr_sel;
  logic             instr_we;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             rf_we;
  logic [1:0]       wb_sel;
  logic             halted;
  logic             illegal;
  logic [31:0]      instret;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  rv32i_control_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .op_class     (op_class),
    .take_branch  (take_branch),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .instr_we     (instr_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .halted       (halted),
    .illegal      (illegal),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [4:0] strobes();
    return {mem_req, mem_we, instr_we, pc_we, rf_we};
  endfunction

  // Hold reset across an edge, check the reset values, release so that
  // the current cycle is cycle 0 (START).
  task automatic do_reset();
    reset       = 1'b1;
    mem_ready   = 1'b0;
    op_class    = '0;
    take_branch = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_outputs", 32'({mem_req, mem_we, mem_addr_sel, instr_we, pc_we,
                            pc_sel, rf_we, wb_sel, halted, illegal}), 32'd0);
    chk("rst_instret", instret, 32'd0);
    reset = 1'b0;
    cyc   = 0;
    #1;
  endtask

  int ops    [4] = '{OPC_ALUIMM, OPC_LUI, OPC_JAL, OPC_JALR};
  int exp_wb [4] = '{0, 3, 2, 2};
  int exp_pcs[4] = '{0, 0, 1, 2};

  initial begin
    reset       = 1'b1;
    op_class    = '0;
    take_branch = 1'b0;
    mem_ready   = 1'b0;

    // ---------------- zero-wait ADDI, LUI, JAL, JALR stream ----------------
    do_reset();
    chk("start_strobes", 32'(strobes()), 32'd0);
    for (int c = 1; c <= 12; c++) begin
      int k;
      int ph;
      step();
      k  = (c - 1) / 3;
      ph = (c - 1) % 3;
      op_class  = 10'd1 << ops[k];
      mem_ready = 1'b1;
      settle();
      chk("stream_pc_we", 32'(pc_we), 32'((c % 3) == 0));
      if (ph == 0) begin
        chk("stream_fetch_req", 32'({mem_req, mem_addr_sel, instr_we}), 32'b101);
      end else if (ph == 1) begin
        chk("stream_decode_quiet", 32'(strobes()), 32'd0);
      end else begin
        chk("stream_rf_we", 32'(rf_we), 32'd1);
        chk("stream_wb_sel", 32'(wb_sel), 32'(exp_wb[k]));
        chk("stream_pc_sel", 32'(pc_sel), 32'(exp_pcs[k]));
      end
    end
    step();
    settle();
    chk("stream_instret", instret, 32'd4);
    chk("stream_refetch", 32'(mem_req), 32'd1);

    // ---------------- load with two MEM wait cycles ----------------
    do_reset();
    op_class  = 10'd1 << OPC_LOAD;
    mem_ready = 1'b1;
    step(); settle();
    chk("ld_fetch", 32'({mem_req, instr_we}), 32'b11);
    step(); settle();
    step(); settle();
    chk("ld_exec_quiet", 32'(strobes()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      mem_ready = (i == 2);
      if (i > 0) op_class = 10'd1 << OPC_STORE;  // late change must not matter
      settle();
      chk("ld_mem_req_addr", 32'({mem_req, mem_addr_sel}), 32'b11);
      chk("ld_mem_we", 32'(mem_we), 32'd0);
      chk("ld_mem_no_pc", 32'({pc_we, rf_we}), 32'd0);
    end
    step();
    mem_ready = 1'b0;
    settle();
    chk("ld_wb", 32'({rf_we, wb_sel, pc_we, pc_sel}), 32'b1_01_1_00);
    chk("ld_wb_no_req", 32'(mem_req), 32'd0);
    step(); settle();
    chk("ld_refetch_c7", 32'({mem_req, mem_addr_sel}), 32'b10);
    chk("ld_instret", instret, 32'd1);

    // ---------------- store with one MEM wait cycle ----------------
    do_reset();
    op_class  = 10'd1 << OPC_STORE;
    mem_ready = 1'b1;
    step(); step();
    step(); settle();
    chk("st_exec_quiet", 32'(strobes()), 32'd0);
    step();
    mem_ready = 1'b0;
    settle();
    chk("st_mem_wait", 32'({mem_req, mem_we, mem_addr_sel, pc_we}), 32'b1110);
    step();
    mem_ready = 1'b1;
    settle();
    chk("st_mem_done", 32'({mem_req, mem_we, pc_we, rf_we}), 32'b1110);
    chk("st_pc_sel", 32'(pc_sel), 32'd0);
    step(); settle();
    chk("st_fetch_no_we", 32'({mem_req, mem_we, mem_addr_sel}), 32'b100);
    chk("st_instret", instret, 32'd1);

    // ---------------- branch taken then not taken ----------------
    do_reset();
    op_class  = 10'd1 << OPC_BRANCH;
    mem_ready = 1'b1;
    step(); step(); step();
    take_branch = 1'b1;
    settle();
    chk("br_taken", 32'({pc_we, pc_sel, rf_we}), 32'b1_01_0);
    step(); step(); step();
    take_branch = 1'b0;
    settle();
    chk("br_not_taken", 32'({pc_we, pc_sel, rf_we}), 32'b1_00_0);
    step(); settle();
    chk("br_instret", instret, 32'd2);

    // ---------------- SYSTEM halt ----------------
    do_reset();
    op_class  = 10'd1 << OPC_SYSTEM;
    mem_ready = 1'b1;
    step(); step(); step(); settle();
    chk("sys_exec_quiet", 32'({pc_we, rf_we, halted}), 32'd0);
    step(); settle();
    chk("sys_halted", 32'({halted, illegal}), 32'b10);
    for (int i = 0; i < 20; i++) begin
      step();
      op_class    = 10'($urandom);
      take_branch = 1'($urandom);
      settle();
      chk("sys_halt_quiet", 32'(strobes()), 32'd0);
    end
    chk("sys_still_halted", 32'({halted, illegal}), 32'b10);
    chk("sys_instret", instret, 32'd0);

    // ---------------- non-one-hot class ----------------
    do_reset();
    chk("ill_cleared", 32'({halted, illegal}), 32'd0);
    op_class  = 10'b0000000011;
    mem_ready = 1'b1;
    step(); step(); step(); settle();
    chk("ill_exec_quiet", 32'({pc_we, rf_we}), 32'd0);
    step(); settle();
    chk("ill_halted", 32'({halted, illegal}), 32'b11);
    for (int i = 0; i < 20; i++) begin
      step();
      op_class = 10'd1 << OPC_ALUREG;
      settle();
      chk("ill_halt_quiet", 32'(strobes()), 32'd0);
    end

    // ---------------- reset during a FETCH wait ----------------
    do_reset();
    op_class  = 10'd1 << OPC_ALUREG;
    mem_ready = 1'b1;
    step(); step(); step();
    step();
    mem_ready = 1'b0;
    settle();
    chk("rf_wait_req", 32'(mem_req), 32'd1);
    chk("rf_pre_instret", instret, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rf_async_drop", 32'(mem_req), 32'd0);
    chk("rf_instret_clr", instret, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    mem_ready = 1'b1;
    settle();
    chk("rf_start_quiet", 32'(strobes()), 32'd0);
    step(); settle();
    chk("rf_refetch", 32'({mem_req, instr_we}), 32'b11);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
